// File: rtl/csel_pipe_adder.sv
// Two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 registers the lower-half sum and both speculative upper-half sums;
// stage 2 selects the upper half using the registered lower-half carry.
module csel_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    // Combinational block sums feeding stage 1
    logic [LO_W:0] lo_add;
    logic [HI_W:0] hi_add0;
    logic [HI_W:0] hi_add1;

    // Stage-1 registers
    logic [LO_W-1:0] lo_sum;
    logic            lo_c;
    logic [HI_W-1:0] hi_sum0;
    logic            hi_c0;
    logic [HI_W-1:0] hi_sum1;
    logic            hi_c1;
    logic            s1_valid;

    // Handshake / advance controls
    logic s2_adv;
    logic s1_adv;
    logic in_xfer;

    // Three independent block adders: lower half, upper half assuming carry 0 and 1
    always_comb begin
        lo_add  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
        hi_add0 = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]};
        hi_add1 = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};
    end

    // Pipeline advance: a stage may load when it is empty or its successor moves on
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv && !rst;
        in_xfer  = in_valid && in_ready;
    end

    // Stage 1: capture the three partial sums whenever the stage can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            lo_sum   <= '0;
            lo_c     <= 1'b0;
            hi_sum0  <= '0;
            hi_c0    <= 1'b0;
            hi_sum1  <= '0;
            hi_c1    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_xfer;
            lo_sum   <= lo_add[LO_W-1:0];
            lo_c     <= lo_add[LO_W];
            hi_sum0  <= hi_add0[HI_W-1:0];
            hi_c0    <= hi_add0[HI_W];
            hi_sum1  <= hi_add1[HI_W-1:0];
            hi_c1    <= hi_add1[HI_W];
        end
    end

    // Stage 2: carry-select mux on the registered lower carry, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            sum       <= {(lo_c ? hi_sum1 : hi_sum0), lo_sum};
            cout      <= lo_c ? hi_c1 : hi_c0;
        end
    end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Scoreboard bench for csel_pipe_adder (WIDTH=16): the driver pushes the
// expected {cout,sum} on every accepted operand, the monitor pops on every
// output transfer.
module tb_csel_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned run = 0;
    int unsigned max_run = 0;
    logic [16:0] sb[$];
    bit          done;

    csel_pipe_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a later negedge after the operand was accepted
    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input logic [16:0] exp, output int unsigned stalls);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 200) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!in_ready) begin
            check("send_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            sb.push_back(exp);
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: sampled mid-cycle, so an output seen here transfers at the next posedge
    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge clk); #1;
            if (out_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready && !rst) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none at %0t", {cout, sum}, $time);
                end else begin
                    exp = sb.pop_front();
                    check("scoreboard", {15'b0, cout, sum}, {15'b0, exp});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned st;
        int unsigned stall_sum;
        logic [15:0] va, vb;
        logic vc;
        logic [16:0] e;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1; done = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_sum", {16'b0, sum}, 0);
        check("rst_cout", {31'b0, cout}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: latency
        send(16'h00FF, 16'h0001, 1'b0, 17'h00100, st);
        in_valid = 1'b0;
        check("t1_lat_cycle1", {31'b0, out_valid}, 0);
        @(negedge clk);
        check("t1_lat_cycle2", {31'b0, out_valid}, 1);
        check("t1_sum", {16'b0, sum}, 32'h0100);
        wait_drain();

        // 2: carry boundaries
        send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, st);
        send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, st);
        in_valid = 1'b0;
        wait_drain();

        // 3: back-to-back stream
        run = 0; max_run = 0; stall_sum = 0;
        send(16'h1234, 16'h1111, 1'b0, 17'h02345, st); stall_sum += st;
        send(16'h8000, 16'h8000, 1'b0, 17'h10000, st); stall_sum += st;
        send(16'h00FF, 16'hFF00, 1'b1, 17'h10000, st); stall_sum += st;
        send(16'h7FFF, 16'h0001, 1'b0, 17'h08000, st); stall_sum += st;
        send(16'hABCD, 16'h5432, 1'b1, 17'h10000, st); stall_sum += st;
        send(16'h0F0F, 16'hF0F0, 1'b0, 17'h0FFFF, st); stall_sum += st;
        send(16'h00FF, 16'h0000, 1'b1, 17'h00100, st); stall_sum += st;
        send(16'hFF00, 16'h0100, 1'b0, 17'h10000, st); stall_sum += st;
        in_valid = 1'b0;
        wait_drain();
        check("t3_no_stall", stall_sum, 0);
        check("t3_consecutive", max_run, 8);

        // 4: backpressure
        out_ready = 1'b0;
        fork
            begin
                send(16'h0001, 16'h0002, 1'b0, 17'h00003, st);
                send(16'h1000, 16'h2000, 1'b1, 17'h03001, st);
                send(16'hC000, 16'h4000, 1'b0, 17'h10000, st);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                check("t4_in_ready_low", {31'b0, in_ready}, 0);
                check("t4_hold_valid", {31'b0, out_valid}, 1);
                check("t4_hold_sum", {16'b0, sum}, 32'h0003);
                check("t4_hold_cout", {31'b0, cout}, 0);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // 5: reset with both stages full
        out_ready = 1'b0;
        send(16'h1111, 16'h1111, 1'b0, 17'h02222, st);
        send(16'h2222, 16'h2222, 1'b0, 17'h04444, st);
        in_valid = 1'b0;
        check("t5_full", {31'b0, out_valid}, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", {31'b0, in_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("t5_flush_valid", {31'b0, out_valid}, 0);
        check("t5_flush_sum", {16'b0, sum}, 0);
        check("t5_flush_cout", {31'b0, cout}, 0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        send(16'h0005, 16'h0003, 1'b1, 17'h00009, st);
        in_valid = 1'b0;
        wait_drain();

        // 6: random traffic
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    va = 16'($urandom);
                    vb = 16'($urandom);
                    vc = 1'($urandom);
                    e  = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
                    send(va, vb, vc, e, st);
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(3) != 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
